// File: rtl/unet_pkg.sv
// Shared U-Net output-side package: collector state encoding,
// default mask threshold and the count-width helper.
package unet_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } seg_state_e;

  localparam logic [15:0] SEG_THRESH_HALF = 16'h0080;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_mask_collector_if.sv
// Packed mask word stream: valid/ready handshake.
// master drives mask_word/mask_valid, slave drives mask_ready.
interface seg_mask_collector_if #(
  parameter int PACK_WIDTH = 32
);
  logic [PACK_WIDTH-1:0] mask_word;
  logic                  mask_valid;
  logic                  mask_ready;

  modport master (
    output mask_word,
    output mask_valid,
    input  mask_ready
  );

  modport slave (
    input  mask_word,
    input  mask_valid,
    output mask_ready
  );
endinterface

// File: rtl/seg_mask_fifo.sv
// Two-entry registered word FIFO; push ignored when full.
// Ports: push/din in, pop/dout/empty out, full, sync clear.
module seg_mask_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic             wr_en;
  logic             rd_en;

  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= !wr_ptr;
      end
      if (rd_en) rd_ptr <= !rd_ptr;
      cnt <= cnt + {1'b0, wr_en} - {1'b0, rd_en};
    end
  end
endmodule

// File: rtl/seg_mask_collector.sv
// Thresholds U-Net seg samples into a packed mask and frame stats.
// Ports: start/threshold, seg_in/seg_valid, unet_done, mask stream
// (interface), tumor_count, bbox_* (SEG_BBOX_EN), frame_done, errors.
module seg_mask_collector
  import unet_pkg::*;
#(
  parameter int IMG_HEIGHT = 256,
  parameter int IMG_WIDTH  = 256,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int PACK_WIDTH = 32,
  localparam int CW  = cnt_w(IMG_HEIGHT * IMG_WIDTH + 1),
  localparam int RW  = cnt_w(IMG_HEIGHT),
  localparam int CLW = cnt_w(IMG_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic [DATA_WIDTH-1:0] seg_in,
  input  logic                  seg_valid,
  input  logic                  unet_done,
  seg_mask_collector_if.master  mask,
  output logic [CW-1:0]         tumor_count,
  output logic [RW-1:0]         bbox_min_row,
  output logic [RW-1:0]         bbox_max_row,
  output logic [CLW-1:0]        bbox_min_col,
  output logic [CLW-1:0]        bbox_max_col,
  output logic                  bbox_valid,
  output logic                  frame_done,
  output logic                  overflow_err,
  output logic                  short_frame_err,
  output logic                  extra_pixel_err
);
  localparam int N  = IMG_HEIGHT * IMG_WIDTH;
  localparam int BW = cnt_w(PACK_WIDTH);

  if (FRAC_WIDTH >= DATA_WIDTH || (N % PACK_WIDTH) != 0) begin : g_cfg_bad
    $error("seg_mask_collector: bad parameters");
  end

  seg_state_e state, state_nxt;

  logic [CW-1:0]         pix_cnt;
  logic [CW-1:0]         run_cnt;
  logic [BW-1:0]         bit_idx;
  logic [PACK_WIDTH-1:0] shreg;
  logic [PACK_WIDTH-1:0] word_nxt;
  logic [DATA_WIDTH-1:0] thr;
  logic                  samp;
  logic                  pix_bit;
  logic                  word_full;
  logic                  last_pix;
  logic                  short_end;
  logic                  push;
  logic                  flush_ok;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [PACK_WIDTH-1:0] fifo_dout;

  seg_mask_fifo #(
    .WIDTH (PACK_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start),
    .push  (push),
    .din   (word_nxt),
    .pop   (mask.mask_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign mask.mask_word  = fifo_dout;
  assign mask.mask_valid = !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = COLLECT;
      COLLECT: begin
        if (start)                       state_nxt = COLLECT;
        else if (last_pix || unet_done)  state_nxt = FLUSH;
      end
      FLUSH: begin
        if (start)           state_nxt = COLLECT;
        else if (fifo_empty) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A short frame pads by pushing whatever bits are pending,
  // including a pixel sampled in the same cycle as unet_done.
  always_comb begin
    samp      = 1'b0;
    pix_bit   = 1'b0;
    word_nxt  = shreg;
    word_full = 1'b0;
    last_pix  = 1'b0;
    short_end = 1'b0;
    push      = 1'b0;
    if (state == COLLECT && !start) begin
      samp    = seg_valid;
      pix_bit = seg_valid && ($signed(seg_in) > $signed(thr));
      if (seg_valid) word_nxt[bit_idx] = pix_bit;
      word_full = seg_valid && (bit_idx == BW'(PACK_WIDTH - 1));
      last_pix  = seg_valid && (pix_cnt == CW'(N - 1));
      short_end = unet_done && !last_pix;
      push = word_full ||
             (short_end && (seg_valid || bit_idx != '0));
    end
    flush_ok = (state == FLUSH) && !start && fifo_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt         <= '0;
      run_cnt         <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      thr             <= '0;
      tumor_count     <= '0;
      frame_done      <= 1'b0;
      overflow_err    <= 1'b0;
      short_frame_err <= 1'b0;
      extra_pixel_err <= 1'b0;
    end else if (start) begin
      pix_cnt         <= '0;
      run_cnt         <= '0;
      bit_idx         <= '0;
      shreg           <= '0;
      thr             <= threshold;
      frame_done      <= 1'b0;
      overflow_err    <= 1'b0;
      short_frame_err <= 1'b0;
      extra_pixel_err <= 1'b0;
    end else begin
      frame_done <= flush_ok;
      if (samp) begin
        pix_cnt <= pix_cnt + 1'b1;
        bit_idx <= word_full ? '0 : bit_idx + 1'b1;
        shreg   <= word_full ? '0 : word_nxt;
        if (pix_bit) run_cnt <= run_cnt + 1'b1;
      end
      if (short_end) begin
        bit_idx         <= '0;
        shreg           <= '0;
        short_frame_err <= 1'b1;
      end
      if (push && fifo_full) overflow_err <= 1'b1;
      if ((state == FLUSH || state == DONE) && seg_valid)
        extra_pixel_err <= 1'b1;
      if (flush_ok) tumor_count <= run_cnt;
    end
  end

`ifdef SEG_BBOX_EN
  logic [RW-1:0]  row, rmin, rmax;
  logic [CLW-1:0] col, cmin, cmax;
  logic           col_last;

  assign col_last = (col == CLW'(IMG_WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row          <= '0;
      col          <= '0;
      rmin         <= '0;
      rmax         <= '0;
      cmin         <= '0;
      cmax         <= '0;
      bbox_min_row <= '0;
      bbox_max_row <= '0;
      bbox_min_col <= '0;
      bbox_max_col <= '0;
      bbox_valid   <= 1'b0;
    end else if (start) begin
      row  <= '0;
      col  <= '0;
      rmin <= RW'(IMG_HEIGHT - 1);
      rmax <= '0;
      cmin <= CLW'(IMG_WIDTH - 1);
      cmax <= '0;
    end else begin
      if (samp) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last)
          row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + 1'b1;
        if (pix_bit) begin
          if (row < rmin) rmin <= row;
          if (row > rmax) rmax <= row;
          if (col < cmin) cmin <= col;
          if (col > cmax) cmax <= col;
        end
      end
      if (flush_ok) begin
        bbox_min_row <= rmin;
        bbox_max_row <= rmax;
        bbox_min_col <= cmin;
        bbox_max_col <= cmax;
        bbox_valid   <= (run_cnt != '0);
      end
    end
  end
`else
  assign bbox_min_row = '0;
  assign bbox_max_row = '0;
  assign bbox_min_col = '0;
  assign bbox_max_col = '0;
  assign bbox_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_seg_mask_collector.sv
// Bench for seg_mask_collector: 4x8 frame, 8-bit words.
// Table frames, random frames vs reference model, corner sequences.
module tb_seg_mask_collector;
  import unet_pkg::*;

  localparam int H   = 4;
  localparam int W   = 8;
  localparam int P   = 8;
  localparam int N   = H * W;
  localparam int NW  = N / P;
  localparam int CW  = cnt_w(N + 1);
  localparam int RW  = cnt_w(H);
  localparam int CLW = cnt_w(W);
`ifdef SEG_BBOX_EN
  localparam bit BB = 1'b1;
`else
  localparam bit BB = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [15:0]    threshold = '0;
  logic [15:0]    seg_in = '0;
  logic           seg_valid = 1'b0;
  logic           unet_done = 1'b0;
  logic [CW-1:0]  tumor_count;
  logic [RW-1:0]  bbox_min_row, bbox_max_row;
  logic [CLW-1:0] bbox_min_col, bbox_max_col;
  logic           bbox_valid, frame_done;
  logic           overflow_err, short_frame_err, extra_pixel_err;

  seg_mask_collector_if #(.PACK_WIDTH(P)) mif ();

  seg_mask_collector #(
    .IMG_HEIGHT (H),
    .IMG_WIDTH  (W),
    .DATA_WIDTH (16),
    .FRAC_WIDTH (8),
    .PACK_WIDTH (P)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .threshold       (threshold),
    .seg_in          (seg_in),
    .seg_valid       (seg_valid),
    .unet_done       (unet_done),
    .mask            (mif),
    .tumor_count     (tumor_count),
    .bbox_min_row    (bbox_min_row),
    .bbox_max_row    (bbox_max_row),
    .bbox_min_col    (bbox_min_col),
    .bbox_max_col    (bbox_max_col),
    .bbox_valid      (bbox_valid),
    .frame_done      (frame_done),
    .overflow_err    (overflow_err),
    .short_frame_err (short_frame_err),
    .extra_pixel_err (extra_pixel_err)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  int         done_cnt = 0;
  bit         lat_chk = 1'b1;
  logic [P-1:0] got [$];
  logic [15:0]  pix [N];

  always @(negedge clk) begin
    if (mif.mask_valid && mif.mask_ready) got.push_back(mif.mask_word);
    if (frame_done) done_cnt++;
  end

  typedef struct {
    logic [15:0] thr;
    logic [15:0] smp;
    logic        exp_bit;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic feed(input logic [15:0] thr, input int n);
    got.delete();
    done_cnt  = 0;
    start     = 1'b1;
    threshold = thr;
    seg_valid = 1'b1;
    seg_in    = 16'h7FFF;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      seg_valid = 1'b1;
      seg_in    = pix[k];
      @(posedge clk); #1;
      if (lat_chk && (k % P) == P - 1)
        chk($sformatf("latency px%0d", k), mif.mask_valid, 1'b1);
    end
    seg_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 200 && done_cnt == 0; i++) @(posedge clk);
    #1;
    chk({nm, " frame_done"}, done_cnt != 0, 1'b1);
  endtask

  task automatic check_model(input string nm, input logic [15:0] thr,
                             input int n, input bit short_exp);
    logic [P-1:0] ew [NW];
    int cnt, rmin, rmax, cmin, cmax, nw;
    cnt  = 0;
    rmin = H - 1;
    rmax = 0;
    cmin = W - 1;
    cmax = 0;
    nw   = (n + P - 1) / P;
    foreach (ew[i]) ew[i] = '0;
    for (int k = 0; k < n; k++) begin
      if ($signed(pix[k]) > $signed(thr)) begin
        ew[k / P][k % P] = 1'b1;
        cnt++;
        if (k / W < rmin) rmin = k / W;
        if (k / W > rmax) rmax = k / W;
        if (k % W < cmin) cmin = k % W;
        if (k % W > cmax) cmax = k % W;
      end
    end
    chk({nm, " count"}, tumor_count, cnt);
    chk({nm, " nwords"}, got.size(), nw);
    for (int i = 0; i < nw; i++)
      chk($sformatf("%s word%0d", nm, i),
          (i < got.size()) ? got[i] : 'x, ew[i]);
    chk({nm, " bbox_valid"}, bbox_valid, BB && cnt != 0);
    chk({nm, " min_row"}, bbox_min_row, BB ? rmin : 0);
    chk({nm, " max_row"}, bbox_max_row, BB ? rmax : 0);
    chk({nm, " min_col"}, bbox_min_col, BB ? cmin : 0);
    chk({nm, " max_col"}, bbox_max_col, BB ? cmax : 0);
    chk({nm, " short_err"}, short_frame_err, short_exp);
    chk({nm, " ovf_err"}, overflow_err, 1'b0);
    chk({nm, " extra_err"}, extra_pixel_err, 1'b0);
  endtask

  task automatic done_once(input string nm);
    repeat (4) @(posedge clk);
    #1;
    chk({nm, " done_once"}, done_cnt, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mif.mask_ready = 1'b1;
    tbl[0] = '{SEG_THRESH_HALF, 16'h0100, 1'b1};
    tbl[1] = '{SEG_THRESH_HALF, 16'h0080, 1'b0};
    tbl[2] = '{SEG_THRESH_HALF, 16'h0081, 1'b1};
    tbl[3] = '{SEG_THRESH_HALF, 16'h007F, 1'b0};
    tbl[4] = '{16'hFF80,        16'hFF00, 1'b0};
    tbl[5] = '{16'hFF80,        16'hFFC0, 1'b1};
    tbl[6] = '{SEG_THRESH_HALF, 16'h8000, 1'b0};
    tbl[7] = '{16'h8000,        16'h7FFF, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst mask_valid", mif.mask_valid, 1'b0);
    chk("rst mask_word", mif.mask_word, '0);
    chk("rst count", tumor_count, '0);
    chk("rst frame_done", frame_done, 1'b0);
    chk("rst errs", {overflow_err, short_frame_err, extra_pixel_err}, '0);
    chk("rst bbox", {bbox_valid, bbox_min_row, bbox_max_row,
                     bbox_min_col, bbox_max_col}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < N; k++) pix[k] = (k % 2 == 0) ? 16'h0100 : 16'h0000;
    feed(SEG_THRESH_HALF, N);
    wait_done("alt");
    check_model("alt", SEG_THRESH_HALF, N, 1'b0);
    chk("alt word0 55", got.size() > 0 ? got[0] : 'x, 8'h55);
    done_once("alt");

    for (int k = 0; k < N; k++) pix[k] = 16'h0080;
    pix[2 * W + 5] = 16'h0081;
    feed(SEG_THRESH_HALF, N);
    wait_done("single");
    check_model("single", SEG_THRESH_HALF, N, 1'b0);
    chk("single word2 20", got.size() > 2 ? got[2] : 'x, 8'h20);
    done_once("single");

    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < N; k++) pix[k] = tbl[t].smp;
      feed(tbl[t].thr, N);
      wait_done($sformatf("tbl%0d", t));
      chk($sformatf("tbl%0d count", t), tumor_count,
          tbl[t].exp_bit ? N : 0);
      chk($sformatf("tbl%0d nwords", t), got.size(), NW);
      for (int i = 0; i < NW; i++)
        chk($sformatf("tbl%0d word%0d", t, i),
            (i < got.size()) ? got[i] : 'x, {P{tbl[t].exp_bit}});
    end

    for (int r = 0; r < 6; r++) begin
      logic [15:0] thr;
      int unsigned d;
      thr = 16'($urandom);
      for (int k = 0; k < N; k++) begin
        d = $urandom_range(0, 4);
        pix[k] = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                              : thr + 16'(d) - 16'd2;
      end
      feed(thr, N);
      wait_done($sformatf("rnd%0d", r));
      check_model($sformatf("rnd%0d", r), thr, N, 1'b0);
    end

    lat_chk = 1'b0;
    mif.mask_ready = 1'b0;
    for (int k = 0; k < N; k++) pix[k] = (k % 2 == 0) ? 16'h0100 : 16'h0000;
    feed(SEG_THRESH_HALF, N);
    repeat (5) @(posedge clk);
    #1;
    chk("ovf err", overflow_err, 1'b1);
    chk("ovf no done yet", done_cnt, 0);
    chk("ovf held valid", mif.mask_valid, 1'b1);
    chk("ovf held word", mif.mask_word, 8'h55);
    mif.mask_ready = 1'b1;
    wait_done("ovf");
    chk("ovf drained", got.size(), 2);
    chk("ovf count", tumor_count, 16);
    chk("ovf err kept", overflow_err, 1'b1);
    lat_chk = 1'b1;

    for (int k = 0; k < N; k++) pix[k] = 16'h7FFF;
    feed(SEG_THRESH_HALF, 12);
    unet_done = 1'b1;
    @(posedge clk); #1;
    unet_done = 1'b0;
    wait_done("short");
    check_model("short", SEG_THRESH_HALF, 12, 1'b1);
    chk("short word1 0F", got.size() > 1 ? got[1] : 'x, 8'h0F);

    seg_valid = 1'b1;
    seg_in    = 16'h7FFF;
    @(posedge clk); #1;
    seg_valid = 1'b0;
    chk("extra err", extra_pixel_err, 1'b1);
    chk("extra count kept", tumor_count, 12);
    done_once("extra");

    for (int k = 0; k < N; k++) pix[k] = 16'h7FFF;
    feed(SEG_THRESH_HALF, 20);
    for (int k = 0; k < N; k++) pix[k] = 16'h0000;
    feed(SEG_THRESH_HALF, N);
    wait_done("abort");
    check_model("abort", SEG_THRESH_HALF, N, 1'b0);

    for (int k = 0; k < N; k++) pix[k] = 16'h7FFF;
    feed(SEG_THRESH_HALF, 10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", mif.mask_valid, 1'b0);
    chk("mid rst count", tumor_count, '0);
    chk("mid rst flags", {frame_done, overflow_err, short_frame_err,
                          extra_pixel_err, bbox_valid}, '0);
    done_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("mid rst no done", done_cnt, 0);
    chk("mid rst idle valid", mif.mask_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seg_mask_collector.md
# seg_mask_collector

Receives the per-pixel segmentation stream leaving the U-Net output stage (sigmoid/final 1×1 conv), thresholds each value into a binary tumour mask, packs mask bits into words and hands them downstream over a valid/ready interface. It also accumulates frame statistics: tumour pixel count, bounding box and protocol errors. It closes the frame against the network's completion pulse and is the receiving end of the U-Net segmentation output interface.

## Interface
- IMG_HEIGHT, 256, frame rows
- IMG_WIDTH, 256, frame columns
- DATA_WIDTH, 16, segmentation sample width, signed fixed point
- FRAC_WIDTH, 8, fractional bits of samples and threshold
- PACK_WIDTH, 32, mask bits per output word; must divide IMG_HEIGHT*IMG_WIDTH
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse that arms collection of a new frame
- threshold  in  DATA_WIDTH  signed Q(DATA_WIDTH-FRAC_WIDTH).FRAC_WIDTH; sampled on start
- seg_in  in  DATA_WIDTH  segmentation sample, raster order
- seg_valid  in  1  seg_in valid this cycle; no backpressure toward the source
- unet_done  in  1  network completion pulse/level
- mask_word  out  PACK_WIDTH  packed mask, pixel k of word at bit k (LSB = earliest pixel)
- mask_valid  out  1  mask_word valid
- mask_ready  in  1  downstream accepts; transfer when mask_valid && mask_ready
- tumor_count  out  $clog2(IMG_HEIGHT*IMG_WIDTH+1)  mask-1 pixels in last completed frame
- bbox_min_row, bbox_max_row  out  $clog2(IMG_HEIGHT)  bounding box rows
- bbox_min_col, bbox_max_col  out  $clog2(IMG_WIDTH)  bounding box columns
- bbox_valid  out  1  tumor_count != 0 for last frame
- frame_done  out  1  one-cycle pulse: frame closed and all words drained
- overflow_err, short_frame_err, extra_pixel_err  out  1 each  sticky error flags, cleared on start

## Operation
- States: IDLE, COLLECT, FLUSH, DONE.
- IDLE/DONE + start → COLLECT. Clears pixel counter, shift register, running stats and error flags. Latches threshold. Running min row/col initialised to IMG_HEIGHT-1/IMG_WIDTH-1, max to 0.
- COLLECT: each seg_valid produces bit = ($signed(seg_in) > $signed(threshold)), a strict signed compare. Row/col counters advance in raster order, with col wrapping at IMG_WIDTH-1 and row incrementing.
- On a 1 bit: count increments and the running bbox updates.
- When the PACK_WIDTH-th bit of a word is sampled, the completed word (including that bit) is pushed to a 2-entry output FIFO. If the FIFO is full, the word is dropped and overflow_err is set.
- Pixel count reaches IMG_HEIGHT*IMG_WIDTH → FLUSH.
- unet_done in COLLECT before the count is reached: the partial word is zero-padded in the upper bits and pushed, short_frame_err is set, and the state goes to FLUSH. A pixel sampled in the same cycle is included before padding.
- FLUSH: seg_valid is ignored and sets extra_pixel_err. Once the FIFO is empty, the stats outputs latch and the state goes to DONE with frame_done high for that one cycle.
- DONE: holds latched stats. seg_valid sets extra_pixel_err. start restarts.
- start in COLLECT/FLUSH: abort and restart. The FIFO is flushed, and any in-flight words are discarded.
- start with seg_valid in the same cycle in IDLE/DONE: the pixel is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty.
- Word latency: mask_valid rises the cycle after the edge sampling the word's final pixel, if the FIFO was empty.
- Sustained throughput: one pixel per clock. With mask_ready held high, the FIFO never overflows.
- mask_word/mask_valid must stay stable while mask_valid && !mask_ready.
- frame_done: at least 1 cycle after the last push, earliest the cycle after FIFO empty. The stats outputs change in the same cycle frame_done rises.
- Reset mid-frame: immediate asynchronous clear. No frame_done is produced.

## Configuration
- SEG_BBOX_EN defined: bbox tracking logic present as above.
- SEG_BBOX_EN undefined: no row/col min/max registers are built. The bbox_* outputs and bbox_valid are tied to 0. tumor_count, packing and the error flags are unchanged.

## Structure
- The shared package unet_pkg holds:
  - state encoding constants (IDLE/COLLECT/FLUSH/DONE)
  - default threshold constant SEG_THRESH_HALF = 0.5 in Q8.8 = 16'h0080
  - the count-width function used for tumor_count and row/col widths
- Sub-module seg_mask_fifo: 2-entry registered FIFO (push, full, pop on valid&&ready, empty), PACK_WIDTH wide.

## Test plan
Use IMG_HEIGHT=4, IMG_WIDTH=8, PACK_WIDTH=8 (32 pixels, 4 words), threshold 16'h0080, mask_ready=1.
- Samples alternating 16'h0100/16'h0000 → four words 8'h55, tumor_count=16, bbox rows 0–3, cols 0–6, frame_done once.
- Single 16'h0081 at row 2 col 5, rest 16'h0080 → word2=8'h20 (others 0), count=1, bbox (2,5)-(2,5), bbox_valid=1.
- mask_ready=0 for the whole frame → two words held, words 3–4 dropped, overflow_err=1. frame_done appears only after mask_ready returns and both held words drain.
- unet_done after 12 pixels, all 16'h7FFF → words 8'hFF, 8'h0F, then short_frame_err=1, count=12, frame_done.
- Extra seg_valid in DONE → extra_pixel_err=1, stats unchanged. Reset asserted mid-frame → all outputs 0, no frame_done.
- Negative samples 16'hFF00 with threshold 16'hFF80 → bit 0. Samples 16'hFFC0 → bit 1 (signed compare check).
